// File: rtl/clock_meter_pkg.sv
// Shared types and constants for the clock period meter.
package clock_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    STALL   = 2'd3
  } meter_state_t;

  localparam int unsigned AVG_DEPTH = 4;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit; chain resets to 0.
module bit_synchronizer #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of measuredClock in masterClock cycles and flags stalls.
// Define CLOCK_METER_AVG_EN to report the period as a running average of the last 4 periods.
module clock_period_meter
  import clock_meter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned COUNT_WIDTH = 16,
  parameter int unsigned TIMEOUT     = 65535
) (
  input  logic                   masterClock,
  input  logic                   masterReset,
  input  logic                   measuredClock,
  input  logic                   enable,
  output logic [COUNT_WIDTH-1:0] period,
  output logic [COUNT_WIDTH-1:0] highTime,
  output logic                   periodValid,
  output logic                   stalled
);

  localparam logic [COUNT_WIDTH-1:0] TimeoutVal = COUNT_WIDTH'(TIMEOUT);
  localparam logic [COUNT_WIDTH-1:0] CntOne     = COUNT_WIDTH'(1);

  logic s, sDly, rise;
  meter_state_t state, stateNext;
  logic [COUNT_WIDTH-1:0] cnt, cntNext, hiCnt, hiCntNext;
  logic [COUNT_WIDTH-1:0] periodNext, highTimeNext, hiInc;
  logic [COUNT_WIDTH-1:0] periodSample;
  logic validNext, stalledNext, sampleReady;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (masterClock),
    .rst (masterReset),
    .d   (measuredClock),
    .q   (s)
  );

  assign rise  = s & ~sDly;
  assign hiInc = (hiCnt == TimeoutVal) ? hiCnt : hiCnt + COUNT_WIDTH'(s);

  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    hiCntNext    = hiCnt;
    periodNext   = period;
    highTimeNext = highTime;
    validNext    = 1'b0;
    stalledNext  = stalled;
    if (!enable) begin
      stateNext   = IDLE;
      cntNext     = '0;
      hiCntNext   = '0;
      stalledNext = 1'b0;
    end else begin
      unique case (state)
        IDLE: stateNext = ARM;
        ARM: begin
          if (rise) begin
            stateNext = MEASURE;
            cntNext   = CntOne;
            hiCntNext = CntOne;
          end
        end
        MEASURE: begin
          if (rise) begin
            if (sampleReady) begin
              periodNext   = periodSample;
              highTimeNext = hiCnt;
              validNext    = 1'b1;
            end
            cntNext   = CntOne;
            hiCntNext = CntOne;
          end else if (cnt == TimeoutVal) begin
            stateNext   = STALL;
            stalledNext = 1'b1;
          end else begin
            // cnt can never pass TIMEOUT here: reaching it diverts to STALL above
            cntNext   = cnt + CntOne;
            hiCntNext = hiInc;
          end
        end
        STALL: begin
          if (rise) begin
            stateNext   = MEASURE;
            stalledNext = 1'b0;
            cntNext     = CntOne;
            hiCntNext   = CntOne;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge masterClock or posedge masterReset) begin
    if (masterReset) begin
      state       <= IDLE;
      sDly        <= 1'b0;
      cnt         <= '0;
      hiCnt       <= '0;
      period      <= '0;
      highTime    <= '0;
      periodValid <= 1'b0;
      stalled     <= 1'b0;
    end else begin
      state       <= stateNext;
      sDly        <= s;
      cnt         <= cntNext;
      hiCnt       <= hiCntNext;
      period      <= periodNext;
      highTime    <= highTimeNext;
      periodValid <= validNext;
      stalled     <= stalledNext;
    end
  end

`ifdef CLOCK_METER_AVG_EN
  localparam int unsigned HistDepth = AVG_DEPTH - 1;
  localparam int unsigned AvgShift  = $clog2(AVG_DEPTH);

  // Older periods only; the current cnt is the newest window entry.
  logic [COUNT_WIDTH-1:0] hist [HistDepth];
  logic [AvgShift-1:0]    histCount;
  logic [COUNT_WIDTH+1:0] avgSum;
  logic                   pushHist, clearHist;

  always_comb begin
    avgSum = {2'b00, cnt};
    for (int i = 0; i < int'(HistDepth); i++) begin
      avgSum = avgSum + {2'b00, hist[i]};
    end
  end

  assign periodSample = COUNT_WIDTH'(avgSum >> AvgShift);
  assign sampleReady  = (histCount == AvgShift'(HistDepth));
  assign pushHist     = enable && (state == MEASURE) && rise;
  assign clearHist    = (stateNext == IDLE) || (stateNext == STALL);

  always_ff @(posedge masterClock or posedge masterReset) begin
    if (masterReset) begin
      histCount <= '0;
      for (int i = 0; i < int'(HistDepth); i++) hist[i] <= '0;
    end else if (clearHist) begin
      histCount <= '0;
      for (int i = 0; i < int'(HistDepth); i++) hist[i] <= '0;
    end else if (pushHist) begin
      hist[0] <= cnt;
      for (int i = 1; i < int'(HistDepth); i++) hist[i] <= hist[i-1];
      if (!sampleReady) histCount <= histCount + AvgShift'(1);
    end
  end
`else
  assign periodSample = cnt;
  assign sampleReady  = 1'b1;
`endif

endmodule
